// File: rtl/jtframe_db9_merge_if.sv
// rtl/jtframe_db9_merge_if.sv - DB9/USB joystick merge bundle
// Signals:
//   db9_en              1 = DB9 path active
//   db9_joy1/db9_joy2   12-bit pad words from the DB9 reader, async to clk
//   usb_joy1/usb_joy2   12-bit USB joystick words, sync to clk
//   joy1/joy2           12-bit merged joystick words, registered
//   db9_present         sticky per-pad presence flags
//   osd_req             one-cycle OSD request pulse
// Modports: master drives the inputs and observes results; slave is the merge block.
interface jtframe_db9_merge_if;
    logic        db9_en;
    logic [11:0] db9_joy1;
    logic [11:0] db9_joy2;
    logic [11:0] usb_joy1;
    logic [11:0] usb_joy2;
    logic [11:0] joy1;
    logic [11:0] joy2;
    logic [1:0]  db9_present;
    logic        osd_req;

    modport master (
        output db9_en, db9_joy1, db9_joy2, usb_joy1, usb_joy2,
        input  joy1, joy2, db9_present, osd_req
    );

    modport slave (
        input  db9_en, db9_joy1, db9_joy2, usb_joy1, usb_joy2,
        output joy1, joy2, db9_present, osd_req
    );
endinterface

// File: rtl/jtframe_db9_merge.sv
// rtl/jtframe_db9_merge.sv - DB9 pad resync/debounce/SOCD filter, USB merge and Mode+Start OSD request
// Ports:
//   clk   system clock
//   rst   synchronous reset, active high
//   bus   jtframe_db9_merge_if.slave (db9_en, db9_joy1/2, usb_joy1/2 in; joy1/2, db9_present, osd_req out)
// Pad word format {M,S,Z,Y,X,C,B,A,U,D,L,R}, 1 = pressed.
module jtframe_db9_merge #(
    parameter int TICK_DIV  = 10,
    parameter int DBW       = 4,
    parameter int CMB_TICKS = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    jtframe_db9_merge_if.slave      bus
);
    localparam logic [DBW-1:0] DB_MAX = '1;
    localparam logic [DBW-1:0] DB_TOP = DB_MAX - 1'b1;
    localparam logic [15:0]    HC_TOP = 16'(CMB_TICKS - 1);

    typedef enum logic [1:0] {IDLE, HOLD, FIRE, WAIT} state_t;

    logic [TICK_DIV-1:0] r_tick_cnt;
    logic                w_tick;
    logic [11:0]         w_in   [2];
    logic [11:0]         r_s1   [2];
    logic [11:0]         r_s2   [2];
    logic [11:0]         r_samp [2];
    logic [11:0]         r_deb  [2];
    logic [DBW-1:0]      r_cnt  [2];
    logic [11:0]         w_f1, w_f2, w_db1;
    logic                w_ms, w_ms_any;
    state_t              r_state, w_state_nx;
    logic [15:0]         r_hcnt;
    logic                w_osd, w_mask;
    logic [11:0]         r_joy1, r_joy2;
    logic [1:0]          r_present;

    function automatic logic [11:0] socd(input logic [11:0] w);
        logic [11:0] r;
        r = w;
        if (w[3] && w[2]) r[3:2] = 2'b00;
        if (w[1] && w[0]) r[1:0] = 2'b00;
        return r;
    endfunction

    assign w_in[0] = bus.db9_joy1;
    assign w_in[1] = bus.db9_joy2;

    // Free-running sample tick, one clk per counter wrap.
    assign w_tick = &r_tick_cnt;
    always_ff @(posedge clk) begin
        if (rst) r_tick_cnt <= '0;
        else     r_tick_cnt <= r_tick_cnt + 1'b1;
    end

    // Resync and debounce; the sync flops keep running while the DB9 path is off.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (rst) begin
                r_s1[p]   <= '0;
                r_s2[p]   <= '0;
                r_samp[p] <= '0;
                r_deb[p]  <= '0;
                r_cnt[p]  <= '0;
            end else begin
                r_s1[p] <= w_in[p];
                r_s2[p] <= r_s1[p];
                if (!bus.db9_en) begin
                    r_samp[p] <= '0;
                    r_deb[p]  <= '0;
                    r_cnt[p]  <= '0;
                end else if (w_tick) begin
                    // A change on the tick always restarts the count, even if deb was due.
                    if (r_s2[p] != r_samp[p]) begin
                        r_samp[p] <= r_s2[p];
                        r_cnt[p]  <= '0;
                    end else if (r_cnt[p] != DB_MAX) begin
                        r_cnt[p] <= r_cnt[p] + 1'b1;
                        if (r_cnt[p] == DB_TOP) r_deb[p] <= r_samp[p];
                    end
                end
            end
        end
    end

    assign w_f1     = socd(r_deb[0]);
    assign w_f2     = socd(r_deb[1]);
    assign w_ms     = w_f1[11] & w_f1[10];
    assign w_ms_any = w_f1[11] | w_f1[10];

    // Combo FSM: state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nx;
    end

    // Combo FSM: next state
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE: if (w_ms) w_state_nx = HOLD;
            HOLD: begin
                if (!w_ms)                          w_state_nx = IDLE;
                else if (w_tick && r_hcnt == HC_TOP) w_state_nx = FIRE;
            end
            FIRE: w_state_nx = WAIT;
            WAIT: if (!w_ms_any) w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
        if (!bus.db9_en) w_state_nx = IDLE;
    end

    // Combo FSM: outputs. Masking follows the next state so the combo is hidden
    // from the very first cycle it is seen, not one cycle late.
    always_comb begin
        w_osd  = (r_state == FIRE);
        w_mask = (w_state_nx != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst || !bus.db9_en || r_state != HOLD) r_hcnt <= '0;
        else if (w_tick)                           r_hcnt <= r_hcnt + 1'b1;
    end

    assign w_db1 = w_mask ? {2'b00, w_f1[9:0]} : w_f1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_joy1    <= '0;
            r_joy2    <= '0;
            r_present <= '0;
        end else begin
            r_joy1 <= bus.usb_joy1 | (bus.db9_en ? w_db1 : 12'h000);
            r_joy2 <= bus.usb_joy2 | (bus.db9_en ? w_f2  : 12'h000);
            if (!bus.db9_en) r_present <= '0;
            else             r_present <= r_present | {|w_f2, |w_f1};
        end
    end

    assign bus.joy1        = r_joy1;
    assign bus.joy2        = r_joy2;
    assign bus.db9_present = r_present;
    assign bus.osd_req     = w_osd;
endmodule

// File: tb/tb_jtframe_db9_merge.sv
// tb/tb_jtframe_db9_merge.sv - self-checking bench for jtframe_db9_merge
module tb_jtframe_db9_merge;
    localparam int CMB = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_osd    = 0;
    bit   chk_on   = 1'b0;

    always #5 clk = ~clk;

    jtframe_db9_merge_if u_if ();

    jtframe_db9_merge #(.TICK_DIV(2), .DBW(2), .CMB_TICKS(CMB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Debounced word = common value of the last four tick samples of the
    // 2-clk-delayed pad input since the DB9 path was (re)enabled.
    logic [11:0] m_d1 [2], m_d2 [2], m_deb [2];
    logic [11:0] m_win [2][4];
    int          m_nt [2];
    int          m_tc;
    logic [11:0] m_joy1, m_joy2;
    logic [1:0]  m_present;
    bit          m_fire, m_latched, m_holding;
    int          m_hticks;

    function automatic logic [11:0] filt(input logic [11:0] w);
        logic [11:0] r;
        r = w;
        if (r[3] && r[2]) r = r & 12'hFF3;
        if (r[1] && r[0]) r = r & 12'hFFC;
        return r;
    endfunction

    always @(posedge clk) begin
        logic [11:0] f0, f1, db0, in_w [2];
        bit ms, ms_any, mask, tick;
        in_w[0] = u_if.db9_joy1;
        in_w[1] = u_if.db9_joy2;
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                m_d1[p] = 0; m_d2[p] = 0; m_deb[p] = 0; m_nt[p] = 0;
            end
            m_tc = 0; m_joy1 = 0; m_joy2 = 0; m_present = 0;
            m_fire = 0; m_latched = 0; m_holding = 0; m_hticks = 0;
        end else begin
            f0     = filt(m_deb[0]);
            f1     = filt(m_deb[1]);
            ms     = f0[11] && f0[10];
            ms_any = f0[11] || f0[10];
            mask   = m_fire || (m_latched ? ms_any : ms);
            db0    = mask ? (f0 & 12'h3FF) : f0;
            m_joy1 = u_if.usb_joy1 | (u_if.db9_en ? db0 : 12'h0);
            m_joy2 = u_if.usb_joy2 | (u_if.db9_en ? f1  : 12'h0);
            tick   = (m_tc == 3);
            m_tc   = (m_tc + 1) % 4;
            if (!u_if.db9_en) begin
                m_present = 0;
                for (int p = 0; p < 2; p++) begin m_deb[p] = 0; m_nt[p] = 0; end
                m_fire = 0; m_latched = 0; m_holding = 0; m_hticks = 0;
            end else begin
                m_present = m_present | {f1 != 0, f0 != 0};
                if (m_fire) begin
                    m_fire = 0; m_latched = 1;
                end else if (m_latched) begin
                    if (!ms_any) m_latched = 0;
                end else if (m_holding) begin
                    if (!ms) m_holding = 0;
                    else if (tick) begin
                        m_hticks++;
                        if (m_hticks == CMB) begin m_fire = 1; m_holding = 0; end
                    end
                end else if (ms) begin
                    m_holding = 1; m_hticks = 0;
                end
                if (tick) begin
                    for (int p = 0; p < 2; p++) begin
                        for (int k = 3; k > 0; k--) m_win[p][k] = m_win[p][k-1];
                        m_win[p][0] = m_d2[p];
                        if (m_nt[p] < 4) m_nt[p]++;
                        if (m_nt[p] == 4 && m_win[p][0] == m_win[p][1] &&
                            m_win[p][1] == m_win[p][2] && m_win[p][2] == m_win[p][3])
                            m_deb[p] = m_win[p][0];
                    end
                end
            end
            for (int p = 0; p < 2; p++) begin
                m_d2[p] = m_d1[p];
                m_d1[p] = in_w[p];
            end
        end
    end

    always @(negedge clk) begin
        if (u_if.osd_req === 1'b1) n_osd++;
        if (chk_on) begin
            check("joy1",    u_if.joy1,        m_joy1);
            check("joy2",    u_if.joy2,        m_joy2);
            check("present", u_if.db9_present, m_present);
            check("osd_req", u_if.osd_req,     m_fire);
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
    endtask

    function automatic logic [11:0] pick_word();
        logic [11:0] pool [8];
        pool[0] = 12'h000; pool[1] = 12'h010; pool[2] = 12'h00F; pool[3] = 12'h009;
        pool[4] = 12'hC00; pool[5] = 12'h800; pool[6] = 12'h400; pool[7] = 12'(($urandom));
        return pool[$urandom_range(0, 7)];
    endfunction

    initial begin
        int base, cyc;
        u_if.db9_en = 1'b1;
        u_if.db9_joy1 = 0; u_if.db9_joy2 = 0; u_if.usb_joy1 = 0; u_if.usb_joy2 = 0;
        wait_clk(3);
        rst = 1'b0;
        check("rst_joy1",    u_if.joy1, 0);
        check("rst_joy2",    u_if.joy2, 0);
        check("rst_present", u_if.db9_present, 0);
        check("rst_osd",     u_if.osd_req, 0);
        chk_on = 1'b1;

        // steady press reaches joy1 within worst-case latency
        u_if.db9_joy1 = 12'h010;
        wait_clk(19);
        check("press_joy1",    u_if.joy1, 12'h010);
        check("press_present", u_if.db9_present, 2'b01);

        // bouncing input never debounces
        do_reset();
        for (int i = 0; i < 100; i++) begin
            u_if.db9_joy1 = ((i / 6) % 2 == 0) ? 12'h010 : 12'h000;
            wait_clk(1);
        end
        check("bounce_joy1",    u_if.joy1, 12'h000);
        check("bounce_present", u_if.db9_present, 2'b00);

        // SOCD on pad 2
        do_reset();
        u_if.db9_joy1 = 0;
        u_if.db9_joy2 = 12'h00F;
        wait_clk(25);
        check("socd_all",  u_if.joy2, 12'h000);
        check("socd_pres", u_if.db9_present, 2'b00);
        u_if.db9_joy2 = 12'h009;
        wait_clk(25);
        check("socd_ur",   u_if.joy2, 12'h009);
        u_if.db9_joy2 = 0;

        // Mode+Start combo: one pulse per hold
        do_reset();
        base = n_osd;
        u_if.db9_joy1 = 12'hC00;
        for (int i = 0; i < 160; i++) begin
            wait_clk(1);
            check("combo_mask", {20'h0, u_if.joy1[11:10]}, 0);
        end
        check("combo_once", n_osd - base, 1);
        u_if.db9_joy1 = 0;
        wait_clk(40);
        u_if.db9_joy1 = 12'hC00;
        wait_clk(80);
        check("combo_twice", n_osd - base, 2);
        u_if.db9_joy1 = 0;

        // USB merge and db9_en drop
        do_reset();
        u_if.usb_joy1 = 12'h020;
        u_if.db9_joy1 = 12'h010;
        wait_clk(25);
        check("merge_or", u_if.joy1, 12'h030);
        u_if.db9_en = 1'b0;
        wait_clk(1);
        check("en_off_joy1",    u_if.joy1, 12'h020);
        check("en_off_present", u_if.db9_present, 2'b00);
        u_if.db9_en = 1'b1;
        u_if.usb_joy1 = 0;
        u_if.db9_joy1 = 0;

        // reset during HOLD, then a full re-hold is needed
        do_reset();
        base = n_osd;
        u_if.db9_joy1 = 12'hC00;
        wait_clk(30);
        rst = 1'b1;
        wait_clk(1);
        check("rst_hold_joy1", u_if.joy1, 0);
        wait_clk(1);
        rst = 1'b0;
        check("rst_hold_osd", n_osd - base, 0);
        cyc = 0;
        while (n_osd == base && cyc < 100) begin
            wait_clk(1);
            cyc++;
        end
        check("rehold_fired", cyc < 100, 1);
        check("rehold_full",  cyc >= 4 * CMB, 1);
        u_if.db9_joy1 = 0;

        // randomized traffic against the model
        for (int seg = 0; seg < 250; seg++) begin
            u_if.db9_joy1 = pick_word();
            u_if.db9_joy2 = pick_word();
            u_if.usb_joy1 = ($urandom_range(0, 1) == 0) ? 12'h0 : 12'($urandom);
            u_if.usb_joy2 = ($urandom_range(0, 1) == 0) ? 12'h0 : 12'($urandom);
            u_if.db9_en   = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                wait_clk(1);
                rst = 1'b0;
            end
            wait_clk($urandom_range(1, 24));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
